// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: the requester drives
// start and operands, the subtractor returns status and the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor
// cell and a borrow flop, result published with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic [CNT_W-1:0] cnt_r;
    logic             a_msb_r;
    logic             b_msb_r;

    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             load_s;
    logic             shift_s;
    logic             complete_s;
    logic             busy_next_s;
    logic             done_next_s;
    logic             last_s;
    logic             d_s;
    logic             br_next_s;

    // Returns {borrow_out, difference} of one full-subtractor cell.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic br);
        logic d;
        logic bo;
        d  = ai ^ bi ^ br;
        bo = (~ai & bi) | (~(ai ^ bi) & br);
        return {bo, d};
    endfunction

    assign {br_next_s, d_s} = full_sub(a_sh_r[0], b_sh_r[0], br_r);
    assign last_s = (state_r == ST_RUN) && (cnt_r == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Per-state datapath controls and next values of the registered status.
    always_comb begin
        load_s      = 1'b0;
        shift_s     = 1'b0;
        complete_s  = 1'b0;
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    load_s      = 1'b1;
                    busy_next_s = 1'b1;
                end else begin
                    busy_next_s = 1'b0;
                end
            end
            ST_RUN: begin
                shift_s = 1'b1;
                if (last_s) begin
                    complete_s  = 1'b1;
                    done_next_s = 1'b1;
                end else begin
                    busy_next_s = 1'b1;
                end
            end
            ST_DONE: begin
                done_next_s = 1'b0;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Operand shift registers, borrow flop, bit counter and published result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            diff_r  <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
            if (load_s) begin
                a_sh_r  <= bus.a;
                b_sh_r  <= bus.b;
                br_r    <= bus.bin;
                res_r   <= {WIDTH{1'b0}};
                cnt_r   <= {CNT_W{1'b0}};
                a_msb_r <= bus.a[WIDTH-1];
                b_msb_r <= bus.b[WIDTH-1];
            end else if (shift_s) begin
                a_sh_r <= a_sh_r >> 1;
                b_sh_r <= b_sh_r >> 1;
                res_r  <= {d_s, res_r[WIDTH-1:1]};
                br_r   <= br_next_s;
                cnt_r  <= cnt_r + CNT_W'(1);
            end
            // The final bit is still in flight, so the result comes from d_s directly.
            if (complete_s) begin
                diff_r <= {d_s, res_r[WIDTH-1:1]};
                bout_r <= br_next_s;
                ovf_r  <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
    assign bus.ovf  = ovf_r;
endmodule
